// File: rtl/madd_pkg.sv
// Shared types and saturation helpers for the multi-lane multiply-add unit.
package madd_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    localparam int SAT_W = 128;

    // Results are returned wide; callers size-cast down to their own width.
    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned width);
        return -(SAT_W'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/VX_multiplier.sv
// Pipelined multiplier: combinational product followed by LATENCY stall-able registers.
module VX_multiplier #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32,
    parameter int R_WIDTH = 64,
    parameter int SIGNED  = 1,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               enable,
    input  logic [A_WIDTH-1:0] dataa,
    input  logic [B_WIDTH-1:0] datab,
    output logic [R_WIDTH-1:0] result
);

    logic [R_WIDTH-1:0] prod;
    logic [R_WIDTH-1:0] pipe_q [LATENCY];

    // Operands are widened before the multiply so the product is exact modulo 2^R_WIDTH.
    if (SIGNED != 0) begin : g_signed
        assign prod = R_WIDTH'($signed(dataa)) * R_WIDTH'($signed(datab));
    end else begin : g_unsigned
        assign prod = R_WIDTH'(dataa) * R_WIDTH'(datab);
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            pipe_q[0] <= prod;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign result = pipe_q[LATENCY-1];

endmodule

// File: rtl/VX_shift_register.sv
// Stall-able fixed-depth delay line for data that has no reset requirement.
module VX_shift_register #(
    parameter int DATAW = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    logic [DATAW-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (enable) begin
            pipe_q[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/madd_lane.sv
// One lane: pipelined signed multiply, delayed addend, final add/accumulate/saturate register.
module madd_lane
    import madd_pkg::*;
#(
    parameter int DATA_SIZE       = 32,
    parameter int ACC_SIZE        = 48,
    parameter int MULTIPLY_CYCLES = 3,
    parameter int SATURATE        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 vld_i,
    input  logic                 mode_i,
    input  logic                 clear_i,
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    input  logic [DATA_SIZE-1:0] c_i,
    output logic [ACC_SIZE-1:0]  result_o,
    output logic                 overflow_o
);

    // Only the low ACC_SIZE+1 product bits ever reach the adder, so the
    // multiplier is built no wider than that.
    localparam int PRW = (ACC_SIZE + 1 < 2 * DATA_SIZE) ? ACC_SIZE + 1 : 2 * DATA_SIZE;
    localparam int SW  = ACC_SIZE + 2;
    localparam logic [ACC_SIZE-1:0] MAX_V = ACC_SIZE'(sat_max(ACC_SIZE));
    localparam logic [ACC_SIZE-1:0] MIN_V = ACC_SIZE'(sat_min(ACC_SIZE));

    logic [PRW-1:0]            prod;
    logic [DATA_SIZE-1:0]      c_dly;
    logic signed [ACC_SIZE:0]  prod_s;
    logic signed [SW-1:0]      base;
    logic signed [SW-1:0]      sum;
    logic                      ovf;
    logic [ACC_SIZE-1:0]       res_d, res_q;
    logic                      ovf_d, ovf_q;

    VX_multiplier #(
        .A_WIDTH (DATA_SIZE),
        .B_WIDTH (DATA_SIZE),
        .R_WIDTH (PRW),
        .SIGNED  (1),
        .LATENCY (MULTIPLY_CYCLES)
    ) u_mul (
        .clk    (clk),
        .enable (enable),
        .dataa  (a_i),
        .datab  (b_i),
        .result (prod)
    );

    VX_shift_register #(
        .DATAW (DATA_SIZE),
        .DEPTH (MULTIPLY_CYCLES)
    ) u_cdly (
        .clk      (clk),
        .enable   (enable),
        .data_in  (c_i),
        .data_out (c_dly)
    );

    assign prod_s = (ACC_SIZE + 1)'($signed(prod));

    always_comb begin
        base = SW'($signed(c_dly));
        if (mode_e'(mode_i) == MODE_ACC) begin
            base = clear_i ? '0 : SW'($signed(res_q));
        end
        sum = SW'(prod_s) + base;
        // In range exactly when every bit above the ACC_SIZE sign bit matches it.
        ovf = ~((&sum[SW-1:ACC_SIZE-1]) | ~(|sum[SW-1:ACC_SIZE-1]));
        res_d = sum[ACC_SIZE-1:0];
        if (ovf && SATURATE != 0) begin
            res_d = sum[SW-1] ? MIN_V : MAX_V;
        end
        ovf_d = ovf_q | ovf;
        if (mode_e'(mode_i) == MODE_ACC && clear_i) begin
            ovf_d = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (enable && vld_i) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign result_o   = res_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/madd_lanes.sv
// Multi-lane pipelined signed multiply-add / multiply-accumulate unit.
module madd_lanes
    import madd_pkg::*;
#(
    parameter int DATA_SIZE       = 32,
    parameter int ACC_SIZE        = 48,
    parameter int LANES           = 4,
    parameter int MULTIPLY_CYCLES = 3,
    parameter int SATURATE        = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       valid_in,
    input  logic                       mode_in,
    input  logic                       clear_in,
    input  logic [LANES*DATA_SIZE-1:0] dataa,
    input  logic [LANES*DATA_SIZE-1:0] datab,
    input  logic [LANES*DATA_SIZE-1:0] datac,
    output logic                       valid_out,
    output logic [LANES*ACC_SIZE-1:0]  result,
    output logic [LANES-1:0]           overflow
);

    localparam int LAST = MULTIPLY_CYCLES - 1;

    logic [MULTIPLY_CYCLES-1:0] vld_pipe_q;
    logic [MULTIPLY_CYCLES-1:0] mode_pipe_q;
    logic [MULTIPLY_CYCLES-1:0] clr_pipe_q;
    logic                       valid_out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe_q  <= '0;
            valid_out_q <= 1'b0;
        end else if (enable) begin
            vld_pipe_q[0] <= valid_in;
            for (int i = 1; i < MULTIPLY_CYCLES; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            valid_out_q <= vld_pipe_q[LAST];
        end
    end

    // Mode/clear are qualified by the valid pipe, so they need no reset.
    always_ff @(posedge clk) begin
        if (enable) begin
            mode_pipe_q[0] <= mode_in;
            clr_pipe_q[0]  <= clear_in;
            for (int i = 1; i < MULTIPLY_CYCLES; i++) begin
                mode_pipe_q[i] <= mode_pipe_q[i-1];
                clr_pipe_q[i]  <= clr_pipe_q[i-1];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        madd_lane #(
            .DATA_SIZE       (DATA_SIZE),
            .ACC_SIZE        (ACC_SIZE),
            .MULTIPLY_CYCLES (MULTIPLY_CYCLES),
            .SATURATE        (SATURATE)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .vld_i      (vld_pipe_q[LAST]),
            .mode_i     (mode_pipe_q[LAST]),
            .clear_i    (clr_pipe_q[LAST]),
            .a_i        (dataa[i*DATA_SIZE +: DATA_SIZE]),
            .b_i        (datab[i*DATA_SIZE +: DATA_SIZE]),
            .c_i        (datac[i*DATA_SIZE +: DATA_SIZE]),
            .result_o   (result[i*ACC_SIZE +: ACC_SIZE]),
            .overflow_o (overflow[i])
        );
    end

    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_madd_lanes.sv
// Bench for madd_lanes: saturating and wrapping instances against an arithmetic reference model.
module tb_madd_lanes;

    localparam int DS  = 32;
    localparam int AS  = 48;
    localparam int LN  = 4;
    localparam int MC  = 3;
    localparam int SH  = 64 - (AS + 1);
    localparam int WSH = 64 - AS;
    localparam longint MAXV = (longint'(1) <<< (AS - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AS - 1));
    localparam longint NOVAL = 64'sh7eadbeefcafe0001;

    logic clk = 1'b0;
    logic rst, en, vin, mode, clr;
    logic [LN*DS-1:0] da, db, dc;
    logic vo_s, vo_w;
    logic [LN*AS-1:0] res_s, res_w;
    logic [LN-1:0] ov_s, ov_w;

    madd_lanes #(.DATA_SIZE(DS), .ACC_SIZE(AS), .LANES(LN), .MULTIPLY_CYCLES(MC), .SATURATE(1)) u_sat (
        .clk(clk), .reset(rst), .enable(en), .valid_in(vin), .mode_in(mode), .clear_in(clr),
        .dataa(da), .datab(db), .datac(dc), .valid_out(vo_s), .result(res_s), .overflow(ov_s));

    madd_lanes #(.DATA_SIZE(DS), .ACC_SIZE(AS), .LANES(LN), .MULTIPLY_CYCLES(MC), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(rst), .enable(en), .valid_in(vin), .mode_in(mode), .clear_in(clr),
        .dataa(da), .datab(db), .datac(dc), .valid_out(vo_w), .result(res_w), .overflow(ov_w));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Operand set presented this cycle
    bit c_v, c_acc, c_clr;
    longint c_a[LN], c_b[LN], c_c[LN];

    // Model: ops in flight, oldest at index MC-1
    bit p_v[MC], p_acc[MC], p_clr[MC];
    longint p_a[MC][LN], p_b[MC][LN], p_c[MC][LN];

    // Model: architectural outputs
    bit m_vo;
    longint m_rs[LN], m_rw[LN];
    bit m_os[LN], m_ow[LN];

    // Lane-0 output log, for scenario-level checks
    longint q_s[$], q_w[$];
    bit q_os[$], q_ow[$];
    int q_cyc[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_of(input logic [LN*AS-1:0] v, input int l);
        logic [AS-1:0] x;
        x = v[l*AS +: AS];
        return longint'($signed(x));
    endfunction

    function automatic longint rnd_small();
        return longint'($signed(16'($urandom())));
    endfunction

    function automatic longint rnd_full();
        return longint'($signed($urandom()));
    endfunction

    task automatic apply(input int l, input bit acc, input bit cl, input longint a, input longint b, input longint c);
        longint p, bs, bw, ss, sw;
        bit os, ow;
        p  = a * b;
        p  = (p <<< SH) >>> SH;
        bs = acc ? (cl ? 64'sd0 : m_rs[l]) : c;
        bw = acc ? (cl ? 64'sd0 : m_rw[l]) : c;
        ss = p + bs;
        sw = p + bw;
        os = (ss > MAXV) || (ss < MINV);
        ow = (sw > MAXV) || (sw < MINV);
        m_rs[l] = (ss > MAXV) ? MAXV : ((ss < MINV) ? MINV : ss);
        m_rw[l] = (sw <<< WSH) >>> WSH;
        m_os[l] = (acc && cl) ? os : (m_os[l] | os);
        m_ow[l] = (acc && cl) ? ow : (m_ow[l] | ow);
    endtask

    task automatic model_edge();
        bit ev, eacc, ecl;
        longint ea[LN], eb[LN], ec[LN];
        if (!rst) begin
            for (int i = 0; i < MC; i++) p_v[i] = 1'b0;
            m_vo = 1'b0;
            for (int l = 0; l < LN; l++) begin
                m_rs[l] = 0; m_rw[l] = 0; m_os[l] = 1'b0; m_ow[l] = 1'b0;
            end
        end else if (en) begin
            ev = p_v[MC-1]; eacc = p_acc[MC-1]; ecl = p_clr[MC-1];
            for (int l = 0; l < LN; l++) begin
                ea[l] = p_a[MC-1][l]; eb[l] = p_b[MC-1][l]; ec[l] = p_c[MC-1][l];
            end
            for (int i = MC - 1; i > 0; i--) begin
                p_v[i] = p_v[i-1]; p_acc[i] = p_acc[i-1]; p_clr[i] = p_clr[i-1];
                for (int l = 0; l < LN; l++) begin
                    p_a[i][l] = p_a[i-1][l]; p_b[i][l] = p_b[i-1][l]; p_c[i][l] = p_c[i-1][l];
                end
            end
            p_v[0] = c_v; p_acc[0] = c_acc; p_clr[0] = c_clr;
            for (int l = 0; l < LN; l++) begin
                p_a[0][l] = c_a[l]; p_b[0][l] = c_b[l]; p_c[0][l] = c_c[l];
            end
            m_vo = ev;
            if (ev) begin
                for (int l = 0; l < LN; l++) apply(l, eacc, ecl, ea[l], eb[l], ec[l]);
            end
        end
    endtask

    task automatic check_all();
        chk("valid_out_sat", longint'(vo_s), longint'(m_vo));
        chk("valid_out_wrap", longint'(vo_w), longint'(m_vo));
        for (int l = 0; l < LN; l++) begin
            chk($sformatf("result_sat[%0d]", l), lane_of(res_s, l), m_rs[l]);
            chk($sformatf("result_wrap[%0d]", l), lane_of(res_w, l), m_rw[l]);
            chk($sformatf("overflow_sat[%0d]", l), longint'(ov_s[l]), longint'(m_os[l]));
            chk($sformatf("overflow_wrap[%0d]", l), longint'(ov_w[l]), longint'(m_ow[l]));
        end
        if (vo_s) begin
            q_s.push_back(lane_of(res_s, 0));
            q_w.push_back(lane_of(res_w, 0));
            q_os.push_back(ov_s[0]);
            q_ow.push_back(ov_w[0]);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic step();
        vin = c_v; mode = c_acc; clr = c_clr;
        for (int l = 0; l < LN; l++) begin
            da[l*DS +: DS] = c_a[l][DS-1:0];
            db[l*DS +: DS] = c_b[l][DS-1:0];
            dc[l*DS +: DS] = c_c[l][DS-1:0];
        end
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    // Lane 0 gets directed operands; other lanes get small random ones.
    task automatic set_op(input bit v, input bit acc, input bit cl, input longint a0, input longint b0, input longint c0);
        c_v = v; c_acc = acc; c_clr = cl;
        c_a[0] = a0; c_b[0] = b0; c_c[0] = c0;
        for (int l = 1; l < LN; l++) begin
            c_a[l] = rnd_small(); c_b[l] = rnd_small(); c_c[l] = rnd_small();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_op(1'b0, 1'($urandom()), 1'($urandom()), rnd_full(), rnd_full(), rnd_full());
            step();
        end
    endtask

    task automatic clear_log();
        q_s.delete(); q_w.delete(); q_os.delete(); q_ow.delete(); q_cyc.delete();
    endtask

    function automatic longint qv(input int which, input int idx);
        case (which)
            0: return (idx < q_s.size())   ? q_s[idx]           : NOVAL;
            1: return (idx < q_w.size())   ? q_w[idx]           : NOVAL;
            2: return (idx < q_os.size())  ? longint'(q_os[idx]) : NOVAL;
            3: return (idx < q_ow.size())  ? longint'(q_ow[idx]) : NOVAL;
            default: return (idx < q_cyc.size()) ? longint'(q_cyc[idx]) : NOVAL;
        endcase
    endfunction

    int t0;

    initial begin
        for (int i = 0; i < MC; i++) p_v[i] = 1'b0;
        m_vo = 1'b0;
        for (int l = 0; l < LN; l++) begin
            m_rs[l] = 0; m_rw[l] = 0; m_os[l] = 1'b0; m_ow[l] = 1'b0;
        end
        en = 1'b1;

        // Reset held with valid_in high, then one cycle after release
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 1'b1, 1'b0, 1000, 1000, 5);
            step();
        end
        rst = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 0, 0, 0);
        step();
        idle(5);

        // Single ADD op: latency and value
        clear_log();
        set_op(1'b1, 1'b0, 1'b0, 7, -6, 100);
        step();
        t0 = cyc;
        idle(5);
        chk("add_count", longint'(q_s.size()), 1);
        chk("add_latency", qv(4, 0) - t0, 3);
        chk("add_lane0", qv(0, 0), 58);

        // Back-to-back accumulate stream
        clear_log();
        set_op(1'b1, 1'b1, 1'b1, 3, 4, 0);   step();
        set_op(1'b1, 1'b1, 1'b0, 5, 6, 0);   step();
        set_op(1'b1, 1'b1, 1'b0, -2, 10, 0); step();
        idle(5);
        chk("acc_count", longint'(q_s.size()), 3);
        chk("acc_out0", qv(0, 0), 12);
        chk("acc_out1", qv(0, 1), 42);
        chk("acc_out2", qv(0, 2), 22);
        chk("acc_back_to_back", qv(4, 2) - qv(4, 0), 2);

        // Same stream with a 5-cycle stall between the 2nd and 3rd op
        clear_log();
        set_op(1'b1, 1'b1, 1'b1, 3, 4, 0);   step();
        t0 = cyc;
        set_op(1'b1, 1'b1, 1'b0, 5, 6, 0);   step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(1'b1, 1'b1, 1'b1, 99, 99, 0);
            step();
        end
        en = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, -2, 10, 0); step();
        idle(6);
        chk("stall_count", longint'(q_s.size()), 3);
        chk("stall_out0", qv(0, 0), 12);
        chk("stall_out1", qv(0, 1), 42);
        chk("stall_out2", qv(0, 2), 22);
        chk("stall_latency", qv(4, 0) - t0, 8);

        // Accumulate past the positive limit, then clear
        clear_log();
        set_op(1'b1, 1'b1, 1'b1, 64'sd8388608, 64'sd8388608, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 1'b1, 1'b0, 64'sd8388608, 64'sd8388608, 0);
            step();
        end
        set_op(1'b1, 1'b1, 1'b1, 1, 1, 0); step();
        idle(5);
        chk("sat_count", longint'(q_s.size()), 5);
        chk("sat_out0", qv(0, 0), longint'(1) <<< 46);
        chk("sat_ovf0", qv(2, 0), 0);
        chk("sat_out1", qv(0, 1), MAXV);
        chk("sat_ovf1", qv(2, 1), 1);
        chk("sat_out3", qv(0, 3), MAXV);
        chk("sat_ovf3", qv(2, 3), 1);
        chk("sat_clear", qv(0, 4), 1);
        chk("sat_clear_ovf", qv(2, 4), 0);
        chk("wrap_out1", qv(1, 1), MINV);
        chk("wrap_out2", qv(1, 2), -(longint'(1) <<< 46));
        chk("wrap_ovf2", qv(3, 2), 1);
        chk("wrap_out3", qv(1, 3), 0);
        chk("wrap_clear", qv(1, 4), 1);
        chk("wrap_clear_ovf", qv(3, 4), 0);

        // Reset with ops in flight
        clear_log();
        set_op(1'b1, 1'b1, 1'b1, 11, 11, 0); step();
        set_op(1'b1, 1'b0, 1'b0, 12, 12, 1); step();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 0, 0, 0); step();
        rst = 1'b1;
        idle(6);
        chk("rst_flush_count", longint'(q_s.size()), 0);
        set_op(1'b1, 1'b1, 1'b1, 2, 3, 0); step();
        t0 = cyc;
        idle(5);
        chk("rst_post_count", longint'(q_s.size()), 1);
        chk("rst_post_latency", qv(4, 0) - t0, 3);
        chk("rst_post_value", qv(0, 0), 6);

        // Random traffic: stalls, occasional resets, mixed modes
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 79) != 0);
            c_v = 1'($urandom());
            c_acc = 1'($urandom());
            c_clr = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < LN; l++) begin
                if (c_acc && $urandom_range(0, 1) == 1) begin
                    c_a[l] = rnd_full(); c_b[l] = rnd_full();
                end else begin
                    c_a[l] = rnd_small(); c_b[l] = rnd_small();
                end
                c_c[l] = rnd_small();
            end
            step();
        end
        en = 1'b1;
        rst = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
